// File: rtl/password_attempt_controller.sv
// Password lock: synchronizes and debounces a check button, evaluates the switch
// code on each debounced press, and runs an unlock / lockout timer FSM.
module password_attempt_controller #(
  parameter logic [3:0]  PASSWORD        = 4'hA,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned UNLOCK_CYCLES   = 500000000,
  parameter int unsigned LOCKOUT_CYCLES  = 1000000000,
  parameter int unsigned MAX_FAILS       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_check,
  input  logic [3:0] password_in,
  output logic       unlocked,
  output logic       lockout,
  output logic [1:0] fail_count,
  output logic       attempt_pulse,
  output logic       attempt_ok,
  output logic [7:0] display_out
);

  localparam int unsigned TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                       : LOCKOUT_CYCLES;
  localparam int TIMER_W = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]         MAX_F        = 2'(MAX_FAILS);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;

  logic             btn_meta, btn_s;
  logic [3:0]       pw_meta, pw_s;
  logic             db, db_q;
  logic [CNT_W-1:0] cnt;
  logic             attempt_evt;
  logic             pw_match;

  function automatic logic [7:0] locked_code(input logic [1:0] fails);
    return {4'hC, 2'b00, MAX_F - fails};
  endfunction

  // The code bus is only looked at on a debounced press, long after the switches
  // settle, so synchronizing each bit independently cannot yield a torn value.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      pw_meta  <= 4'h0;
      pw_s     <= 4'h0;
      // NOTE: db and its delayed copy reset high so a button held across reset
      // never looks like a fresh 0->1 press.
      db       <= 1'b1;
      db_q     <= 1'b1;
      cnt      <= '0;
    end else begin
      btn_meta <= btn_check;
      btn_s    <= btn_meta;
      pw_meta  <= password_in;
      pw_s     <= pw_meta;
      db_q     <= db;
      if (btn_s == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= btn_s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign attempt_evt = db & ~db_q;
  assign pw_match    = (pw_s == PASSWORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_LOCKED;
      timer         <= '0;
      fail_count    <= 2'd0;
      unlocked      <= 1'b0;
      lockout       <= 1'b0;
      attempt_pulse <= 1'b0;
      attempt_ok    <= 1'b0;
      display_out   <= locked_code(2'd0);
    end else begin
      // NOTE: these defaults are overridden by any later non-blocking assignment
      // in this block, which is what makes the strobe last exactly one cycle.
      attempt_pulse <= 1'b0;
      attempt_ok    <= 1'b0;
      unique case (state)
        ST_LOCKED: begin
          if (attempt_evt) begin
            attempt_pulse <= 1'b1;
            if (pw_match) begin
              state       <= ST_UNLOCKED;
              fail_count  <= 2'd0;
              timer       <= UNLOCK_LOAD;
              unlocked    <= 1'b1;
              attempt_ok  <= 1'b1;
              display_out <= 8'h0E;
            end else if (fail_count == MAX_F - 2'd1) begin
              state       <= ST_LOCKOUT;
              fail_count  <= MAX_F;
              timer       <= LOCKOUT_LOAD;
              lockout     <= 1'b1;
              display_out <= 8'hFF;
            end else begin
              fail_count  <= fail_count + 2'd1;
              display_out <= locked_code(fail_count + 2'd1);
            end
          end
        end
        ST_UNLOCKED: begin
          if (timer == '0) begin
            state       <= ST_LOCKED;
            unlocked    <= 1'b0;
            display_out <= locked_code(fail_count);
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        ST_LOCKOUT: begin
          if (timer == '0) begin
            state       <= ST_LOCKED;
            fail_count  <= 2'd0;
            lockout     <= 1'b0;
            display_out <= locked_code(2'd0);
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        default: begin
          state <= ST_LOCKED;
        end
      endcase
    end
  end

endmodule
